// File: rtl/axi_lite_if.sv
// AXI4-Lite channel bundle shared between one master and its slaves.
// Carries the AW/W/B/AR/R channels; protection signals are not modelled.
interface axi_lite_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding request/response port bridged onto an AXI4-Lite master.
// Optional AXI_MASTER_ALIGN_CHECK_EN: misaligned requests are answered with an error, no AXI traffic.
module axi_lite_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy,
    axi_lite_if.master          m
);
    typedef enum logic [2:0] {StIdle, StRdAddr, StRdData, StWrReq, StWrResp, StResp} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

`ifdef AXI_MASTER_ALIGN_CHECK_EN
    localparam int unsigned OffW = $clog2(DATA_W / 8);
    logic misaligned;
    assign misaligned = |req_addr[OffW-1:0];
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    rdata_d   = '0;
                    err_d     = 1'b0;
                    state_d   = req_we ? StWrReq : StRdAddr;
`ifdef AXI_MASTER_ALIGN_CHECK_EN
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
`endif
                end
            end
            StRdAddr: begin
                if (m.arready) state_d = StRdData;
            end
            StRdData: begin
                if (m.rvalid) begin
                    rdata_d = m.rdata;
                    err_d   = |m.rresp;
                    state_d = StResp;
                end
            end
            StWrReq: begin
                // Each channel retires on its own handshake; leave once both have.
                aw_done_d = aw_done_q | m.awready;
                w_done_d  = w_done_q | m.wready;
                if (aw_done_d && w_done_d) state_d = StWrResp;
            end
            StWrResp: begin
                if (m.bvalid) begin
                    rdata_d = '0;
                    err_d   = |m.bresp;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // All AXI outputs decode from registers only, so reset clears them asynchronously.
    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    assign m.arvalid = (state_q == StRdAddr);
    assign m.araddr  = addr_q;
    assign m.rready  = (state_q == StRdData);
    assign m.awvalid = (state_q == StWrReq) && !aw_done_q;
    assign m.awaddr  = addr_q;
    assign m.wvalid  = (state_q == StWrReq) && !w_done_q;
    assign m.wdata   = wdata_q;
    assign m.wstrb   = wstrb_q;
    assign m.bready  = (state_q == StWrResp);
endmodule

// File: tb/tb_axi_lite_master.sv
// Scoreboard bench for axi_lite_master: directed requests push expected AXI and response
// items into queues, a negedge monitor pops and compares them as the DUT presents them.
module tb_axi_lite_master;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    axi_lite_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .m         (bus)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- slave model ----------------
    int          ar_wait = 0, aw_wait = 0, w_wait = 0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = '0, s_bresp = '0;
    int          ar_cnt, aw_cnt, w_cnt;
    logic        r_pend, b_pend, aw_seen, w_seen;
    logic [31:0] r_data_q;
    int          b_count = 0, ar_cycles = 0, aw_after_w = 0;

    logic ar_hs, aw_hs, w_hs;
    assign ar_hs = bus.arvalid && bus.arready;
    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid && bus.wready;

    assign bus.arready = bus.arvalid && (ar_cnt >= ar_wait);
    assign bus.awready = bus.awvalid && (aw_cnt >= aw_wait);
    assign bus.wready  = bus.wvalid && (w_cnt >= w_wait);
    assign bus.rvalid  = r_pend;
    assign bus.rdata   = r_pend ? r_data_q : 32'h0;
    assign bus.rresp   = s_rresp;
    assign bus.bvalid  = b_pend;
    assign bus.bresp   = s_bresp;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0;
            r_pend <= 1'b0; b_pend <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0;
            r_data_q <= '0;
        end else begin
            ar_cnt <= (bus.arvalid && !bus.arready) ? ar_cnt + 1 : 0;
            aw_cnt <= (bus.awvalid && !bus.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (bus.wvalid && !bus.wready) ? w_cnt + 1 : 0;
            if (bus.arvalid) ar_cycles <= ar_cycles + 1;
            if (w_seen && bus.awvalid) aw_after_w <= aw_after_w + 1;
            if (ar_hs) begin
                r_pend   <= 1'b1;
                r_data_q <= s_rdata;
            end else if (bus.rvalid && bus.rready) begin
                r_pend <= 1'b0;
            end
            if (b_pend && bus.bready) begin
                b_pend <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0;
                b_count <= b_count + 1;
            end else begin
                if (aw_hs) aw_seen <= 1'b1;
                if (w_hs) w_seen <= 1'b1;
                if ((aw_seen || aw_hs) && (w_seen || w_hs) && !b_pend) b_pend <= 1'b1;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [31:0] ar_q[$];
    logic [31:0] aw_q[$];
    logic [35:0] w_q[$];
    logic [32:0] rsp_q[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (ar_hs) begin
                chk("ar_expected", 64'(ar_q.size() != 0), 64'd1);
                if (ar_q.size() != 0) chk("araddr", bus.araddr, ar_q.pop_front());
            end
            if (aw_hs) begin
                chk("aw_expected", 64'(aw_q.size() != 0), 64'd1);
                if (aw_q.size() != 0) chk("awaddr", bus.awaddr, aw_q.pop_front());
            end
            if (w_hs) begin
                chk("w_expected", 64'(w_q.size() != 0), 64'd1);
                if (w_q.size() != 0) chk("wdata_wstrb", {bus.wdata, bus.wstrb}, w_q.pop_front());
            end
            if (w_seen && bus.awvalid) chk("wvalid_dropped", bus.wvalid, 1'b0);
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", 64'(rsp_q.size() != 0), 64'd1);
                if (rsp_q.size() != 0) chk("rsp_err_rdata", {rsp_err, rsp_rdata}, rsp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                          input logic exp_err, input bit axi, input int hold,
                          input int exp_lat, input bit probe);
        int lat;
        if (axi) begin
            if (we) begin
                aw_q.push_back(addr);
                w_q.push_back({wdata, wstrb});
            end else begin
                ar_q.push_back(addr);
            end
        end
        rsp_q.push_back({exp_err, exp_rdata});
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        chk("req_accept", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        lat = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
            lat++;
        end
        chk("rsp_valid_seen", rsp_valid, 1'b1);
        if (exp_lat > 0) chk("latency", 64'(lat), 64'(exp_lat));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (probe) begin
                // Competing request while the response is still pending
                req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_1000;
            end
            @(negedge clk);
            chk("hold_rsp_valid", rsp_valid, 1'b1);
            chk("hold_rsp_rdata", rsp_rdata, exp_rdata);
            chk("hold_rsp_err", rsp_err, exp_err);
            chk("hold_req_ready", req_ready, 1'b0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0; req_addr = '0;
        @(negedge clk);
        chk("busy_after_rsp", busy, 1'b0);
    endtask

    int ar_before, b_before, aw_w_before;

    initial begin
        // Reset state, checked both while held and after release
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_outs", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready, rsp_valid},
            6'b0);
        chk("rst_rsp", {rsp_err, rsp_rdata}, 33'h0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", req_ready, 1'b1);
        chk("idle_outs", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}, 5'b0);

        // Read with arready after 2 wait cycles: arvalid up 3 cycles including handshake
        ar_wait = 2; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00;
        ar_before = ar_cycles;
        do_req(1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 0, 5, 1'b0);
        chk("ar_valid_cycles", 64'(ar_cycles - ar_before), 64'd3);
        ar_wait = 0;

        // Zero-wait read latency
        s_rdata = 32'h0123_4567;
        do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h0123_4567, 1'b0, 1'b1, 0, 3, 1'b0);

        // Write case 1: W handshakes 3 cycles before AW
        aw_wait = 3; w_wait = 0; s_bresp = 2'b00;
        b_before = b_count; aw_w_before = aw_after_w;
        do_req(1'b1, 32'hA000_03F8, 32'h41, 4'h1, 32'h0, 1'b0, 1'b1, 0, 6, 1'b0);
        chk("case1_one_b", 64'(b_count - b_before), 64'd1);
        chk("case1_aw_after_w", 64'(aw_after_w - aw_w_before), 64'd3);

        // Write case 2: both handshakes in the same cycle
        aw_wait = 0; w_wait = 0;
        b_before = b_count; aw_w_before = aw_after_w;
        do_req(1'b1, 32'hA000_03F8, 32'h41, 4'h1, 32'h0, 1'b0, 1'b1, 0, 3, 1'b0);
        chk("case2_one_b", 64'(b_count - b_before), 64'd1);
        chk("case2_aw_after_w", 64'(aw_after_w - aw_w_before), 64'd0);

        // Error responses
        s_rdata = 32'hCAFE_F00D; s_rresp = 2'b10;
        do_req(1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b1, 1'b1, 0, 3, 1'b0);
        s_rresp = 2'b00; s_bresp = 2'b11;
        do_req(1'b1, 32'h0000_0030, 32'h55AA_00FF, 4'hC, 32'h0, 1'b1, 1'b1, 0, 3, 1'b0);
        s_bresp = 2'b00;

        // Response back-pressure with a competing request held during it
        s_rdata = 32'h5A5A_A5A5;
        do_req(1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'h5A5A_A5A5, 1'b0, 1'b1, 5, 3, 1'b1);

        // Reset while AW/W are pending: everything clears asynchronously, no response
        aw_wait = 20; w_wait = 20;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0050; req_wdata = 32'h77;
        req_wstrb = 4'hF;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.awvalid) break;
        end
        chk("wr_awvalid_up", bus.awvalid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_outs",
            {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready, rsp_valid}, 6'b0);
        chk("async_rst_busy", busy, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
        aw_wait = 0; w_wait = 0;
        s_rdata = 32'h1357_9BDF;
        do_req(1'b0, 32'h0000_0060, 32'h0, 4'h0, 32'h1357_9BDF, 1'b0, 1'b1, 0, 3, 1'b0);

        // Misaligned read
        s_rdata = 32'h2468_ACE0;
        ar_before = ar_cycles;
`ifdef AXI_MASTER_ALIGN_CHECK_EN
        do_req(1'b0, 32'h8000_0002, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 0, 1, 1'b0);
        chk("misaligned_no_ar", 64'(ar_cycles - ar_before), 64'd0);
`else
        do_req(1'b0, 32'h8000_0002, 32'h0, 4'h0, 32'h2468_ACE0, 1'b0, 1'b1, 0, 3, 1'b0);
        chk("misaligned_ar_issued", 64'(ar_cycles - ar_before), 64'd1);
`endif

        repeat (3) @(negedge clk);
        chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
        chk("axi_q_drained", 64'(ar_q.size() + aw_q.size() + w_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #200000;
        chk("global_timeout", 64'd1, 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
